instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
Initiator side of the instruction-memory interface: owns the PC, drives the byte address into the combinational, big-endian, 16 KB instruction memory, and captures the returned word into the IF/ID pipeline register. Handles stall, branch/jump redirect with IF/ID flush, and range/alignment faults. Sits between hazard/branch logic (EX/ID) and decode.

Parameters:
RESET_PC, 32'd100, PC value loaded on reset (first test program address).
IMEM_BYTES, 16384, instruction memory size in bytes; legal fetch requires pc <= IMEM_BYTES-4.
NOP_WORD, 32'h00000000, word injected into IF/ID on bubble/flush/fault.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
stall  in  1  hold PC and IF/ID (load-use hazard).
branch_taken  in  1  redirect to branch_target.
branch_target  in  32  byte address of taken branch.
jump  in  1  redirect to jump_target.
jump_target  in  32  byte address of jump.
imem_addr  out  32  byte address to instruction memory (= pc_q).
imem_data  in  32  word returned combinationally by memory for imem_addr.
if_id_instr  out  32  registered instruction for decode.
if_id_pc4  out  32  registered PC+4 of that instruction.
if_id_valid  out  1  1 = if_id_instr is a real fetched instruction.
pc_q  out  32  current PC.
fetch_fault  out  1  sticky: misaligned redirect or out-of-range fetch.

Behaviour:
- Reset (async, rst_n=0): pc_q=RESET_PC, if_id_instr=NOP_WORD, if_id_pc4=0, if_id_valid=0, fetch_fault=0. Release takes effect on next rising edge; first valid IF/ID word appears 1 cycle after release.
- imem_addr = pc_q, combinational; memory read latency 0, IF/ID latency 1 cycle.
- in_range = (pc_q <= IMEM_BYTES-4). Next-state priority per cycle, highest first:
  1. Redirect (jump or branch_taken; jump wins if both): pc_q <= {target[31:2],2'b00}; IF/ID <= bubble (NOP_WORD, pc4=0, valid=0). Redirect overrides stall. If target[1:0]!=0, fetch_fault <= 1.
  2. stall: pc_q and all IF/ID outputs hold.
  3. !in_range: pc_q holds, IF/ID <= bubble, fetch_fault <= 1.
  4. Normal: pc_q <= pc_q+4; if_id_instr <= imem_data; if_id_pc4 <= pc_q+4; if_id_valid <= 1.
- pc_q+4 is 32-bit modulo arithmetic; wrap only reachable via redirect, and range check catches it.
- Redirect target out of range: loaded anyway; fault raised on following cycle by rule 3.
- fetch_fault sticky until reset; does not otherwise stop fetching except via rule 3.
- Reset mid-stall or mid-redirect: reset wins immediately, all state as above.
- State machine: RUN (rules 1,2,4) / HOLD_FAULT (pc out of range, rule 3); HOLD_FAULT -> RUN only on redirect to in-range target or reset.

Optional Feature:
Macro FETCH_PERF_CNT_EN. Defined: adds outputs perf_fetched[31:0] (increments on each rule-4 cycle) and perf_bubbles[31:0] (increments on each cycle IF/ID loads a bubble via rule 1 or 3, not on stall); both reset to 0, saturate at 32'hFFFFFFFF. Not defined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, memory holds 0x48080000 at 100, 0x48090004 at 104 -> pc_q=100; after edge 1 if_id_instr=0x48080000, if_id_pc4=104, valid=1; after edge 2 if_id_instr=0x48090004, pc_q=108.
- Assert stall 2 cycles at pc_q=108 -> pc_q stays 108, IF/ID unchanged; release -> pc_q=112.
- branch_taken=1, branch_target=500, stall=1 same cycle -> pc_q=500, if_id_valid=0, if_id_instr=0; next edge fetches word at 500, valid=1.
- jump=1 target=600 and branch_taken=1 target=200 together -> pc_q=600.
- jump_target=0x202 -> pc_q=0x200, fetch_fault=1, stays 1 after further normal fetches.
- Redirect to 16380 -> one valid fetch, pc_q=16384, then bubbles, pc_q held, fetch_fault=1; redirect to 100 resumes; pull rst_n low mid-run -> pc_q=100, valid=0, fault=0 asynchronously.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bus: hazard/branch controls in, instruction-memory port, IF/ID register out.
// With FETCH_PERF_CNT_EN defined the bus also carries the fetch/bubble counters.
interface instruction_fetch_unit_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [31:0] pc_q;
    logic        fetch_fault;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;
`endif

    modport master (
        input  stall, branch_taken, branch_target, jump, jump_target, imem_data,
        output imem_addr, if_id_instr, if_id_pc4, if_id_valid, pc_q, fetch_fault
`ifdef FETCH_PERF_CNT_EN
        , output perf_fetched, perf_bubbles
`endif
    );

    modport slave (
        output stall, branch_taken, branch_target, jump, jump_target, imem_data,
        input  imem_addr, if_id_instr, if_id_pc4, if_id_valid, pc_q, fetch_fault
`ifdef FETCH_PERF_CNT_EN
        , input perf_fetched, perf_bubbles
`endif
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, addresses the combinational imem, loads IF/ID.
// Optional FETCH_PERF_CNT_EN adds saturating fetched/bubble counters.
//
// state      | meaning
// RUN        | pc_q in range; fetching sequentially (or stalled)
// HOLD_FAULT | pc_q out of range; PC held, IF/ID fed bubbles until a redirect
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'd100,
    parameter int          IMEM_BYTES = 16384,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    instruction_fetch_unit_if.master  bus
);
    localparam logic [31:0] PC_LIMIT = 32'(IMEM_BYTES - 4);

    typedef enum logic [0:0] {RUN, HOLD_FAULT} state_t;

    localparam state_t RESET_STATE = (RESET_PC <= PC_LIMIT) ? RUN : HOLD_FAULT;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;
    logic        fetched;
    logic        bubble;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] target_aligned;
    logic [31:0] pc_plus4;

    assign redirect       = bus.jump | bus.branch_taken;
    assign target         = bus.jump ? bus.jump_target : bus.branch_target;
    assign target_aligned = {target[31:2], 2'b00};
    assign pc_plus4       = pc_q + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET_STATE;
            pc_q    <= RESET_PC;
            instr_q <= NOP_WORD;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    // Redirect beats stall; stall beats the out-of-range bubble.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        fault_d = fault_q;
        fetched = 1'b0;
        bubble  = 1'b0;
        if (redirect) begin
            pc_d    = target_aligned;
            bubble  = 1'b1;
            state_d = (target_aligned <= PC_LIMIT) ? RUN : HOLD_FAULT;
            if (target[1:0] != 2'b00) fault_d = 1'b1;
        end else if (!bus.stall) begin
            case (state_q)
                RUN: begin
                    pc_d    = pc_plus4;
                    instr_d = bus.imem_data;
                    pc4_d   = pc_plus4;
                    valid_d = 1'b1;
                    fetched = 1'b1;
                    state_d = (pc_plus4 <= PC_LIMIT) ? RUN : HOLD_FAULT;
                end
                HOLD_FAULT: begin
                    bubble  = 1'b1;
                    fault_d = 1'b1;
                end
                default: state_d = RUN;
            endcase
        end
        if (bubble) begin
            instr_d = NOP_WORD;
            pc4_d   = 32'd0;
            valid_d = 1'b0;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.pc_q        = pc_q;
    assign bus.if_id_instr = instr_q;
    assign bus.if_id_pc4   = pc4_q;
    assign bus.if_id_valid = valid_q;
    assign bus.fetch_fault = fault_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_bubbles_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= 32'd0;
            perf_bubbles_q <= 32'd0;
        end else begin
            if (fetched && perf_fetched_q != 32'hFFFF_FFFF) perf_fetched_q <= perf_fetched_q + 32'd1;
            if (bubble && perf_bubbles_q != 32'hFFFF_FFFF)  perf_bubbles_q <= perf_bubbles_q + 32'd1;
        end
    end

    assign bus.perf_fetched = perf_fetched_q;
    assign bus.perf_bubbles = perf_bubbles_q;
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a small combinational imem model.
module tb_instruction_fetch_unit;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two fixed program words; every other address returns addr ^ 0xC0DE0000.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd100) return 32'h4808_0000;
        if (a == 32'd104) return 32'h4809_0004;
        return a ^ 32'hC0DE_0000;
    endfunction

    assign bus.imem_data = mem_word(bus.imem_addr);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        // inline-style comparison body kept identical in every use
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic clear_ctrl();
        bus.stall = 0; bus.branch_taken = 0; bus.jump = 0;
        bus.branch_target = 0; bus.jump_target = 0;
    endtask

    task automatic test_reset();
        clear_ctrl();
        rst_n = 0;
        #12;
        n_checks++; if (bus.pc_q !== 32'd100) begin n_fail++; $display("FAIL rst_pc: got %h expected %h", bus.pc_q, 32'd100); end
        n_checks++; if (bus.imem_addr !== 32'd100) begin n_fail++; $display("FAIL rst_addr: got %h expected %h", bus.imem_addr, 32'd100); end
        n_checks++; if (bus.if_id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", bus.if_id_valid); end
        n_checks++; if (bus.if_id_instr !== 32'd0) begin n_fail++; $display("FAIL rst_instr: got %h expected 0", bus.if_id_instr); end
        n_checks++; if (bus.if_id_pc4 !== 32'd0) begin n_fail++; $display("FAIL rst_pc4: got %h expected 0", bus.if_id_pc4); end
        n_checks++; if (bus.fetch_fault !== 1'b0) begin n_fail++; $display("FAIL rst_fault: got %b expected 0", bus.fetch_fault); end
        @(negedge clk);
        rst_n = 1;
        step();
        n_checks++; if (bus.if_id_instr !== 32'h4808_0000) begin n_fail++; $display("FAIL f1_instr: got %h expected 48080000", bus.if_id_instr); end
        n_checks++; if (bus.if_id_pc4 !== 32'd104) begin n_fail++; $display("FAIL f1_pc4: got %h expected %h", bus.if_id_pc4, 32'd104); end
        n_checks++; if (bus.if_id_valid !== 1'b1) begin n_fail++; $display("FAIL f1_valid: got %b expected 1", bus.if_id_valid); end
        step();
        n_checks++; if (bus.if_id_instr !== 32'h4809_0004) begin n_fail++; $display("FAIL f2_instr: got %h expected 48090004", bus.if_id_instr); end
        n_checks++; if (bus.pc_q !== 32'd108) begin n_fail++; $display("FAIL f2_pc: got %h expected %h", bus.pc_q, 32'd108); end
    endtask

    task automatic test_stall();
        bus.stall = 1;
        step(); step();
        n_checks++; if (bus.pc_q !== 32'd108) begin n_fail++; $display("FAIL stall_pc: got %h expected %h", bus.pc_q, 32'd108); end
        n_checks++; if (bus.if_id_instr !== 32'h4809_0004) begin n_fail++; $display("FAIL stall_instr: got %h expected 48090004", bus.if_id_instr); end
        n_checks++; if (bus.if_id_pc4 !== 32'd108) begin n_fail++; $display("FAIL stall_pc4: got %h expected %h", bus.if_id_pc4, 32'd108); end
        n_checks++; if (bus.if_id_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got %b expected 1", bus.if_id_valid); end
        bus.stall = 0;
        step();
        n_checks++; if (bus.pc_q !== 32'd112) begin n_fail++; $display("FAIL unstall_pc: got %h expected %h", bus.pc_q, 32'd112); end
        n_checks++; if (bus.if_id_instr !== 32'hC0DE_006C) begin n_fail++; $display("FAIL unstall_instr: got %h expected c0de006c", bus.if_id_instr); end
    endtask

    task automatic test_branch_over_stall();
        bus.branch_taken = 1; bus.branch_target = 32'd500; bus.stall = 1;
        step();
        clear_ctrl();
        n_checks++; if (bus.pc_q !== 32'd500) begin n_fail++; $display("FAIL br_pc: got %h expected %h", bus.pc_q, 32'd500); end
        n_checks++; if (bus.if_id_valid !== 1'b0) begin n_fail++; $display("FAIL br_valid: got %b expected 0", bus.if_id_valid); end
        n_checks++; if (bus.if_id_instr !== 32'd0) begin n_fail++; $display("FAIL br_instr: got %h expected 0", bus.if_id_instr); end
        n_checks++; if (bus.if_id_pc4 !== 32'd0) begin n_fail++; $display("FAIL br_pc4: got %h expected 0", bus.if_id_pc4); end
        step();
        n_checks++; if (bus.if_id_instr !== 32'hC0DE_01F4) begin n_fail++; $display("FAIL br_fetch_instr: got %h expected c0de01f4", bus.if_id_instr); end
        n_checks++; if (bus.if_id_pc4 !== 32'd504) begin n_fail++; $display("FAIL br_fetch_pc4: got %h expected %h", bus.if_id_pc4, 32'd504); end
        n_checks++; if (bus.if_id_valid !== 1'b1) begin n_fail++; $display("FAIL br_fetch_valid: got %b expected 1", bus.if_id_valid); end
    endtask

    task automatic test_jump_priority();
        bus.jump = 1; bus.jump_target = 32'd600;
        bus.branch_taken = 1; bus.branch_target = 32'd200;
        step();
        clear_ctrl();
        n_checks++; if (bus.pc_q !== 32'd600) begin n_fail++; $display("FAIL jmp_pc: got %h expected %h", bus.pc_q, 32'd600); end
        n_checks++; if (bus.fetch_fault !== 1'b0) begin n_fail++; $display("FAIL jmp_fault: got %b expected 0", bus.fetch_fault); end
    endtask

    task automatic test_misaligned();
        bus.jump = 1; bus.jump_target = 32'h202;
        step();
        clear_ctrl();
        n_checks++; if (bus.pc_q !== 32'h200) begin n_fail++; $display("FAIL mis_pc: got %h expected 00000200", bus.pc_q); end
        n_checks++; if (bus.fetch_fault !== 1'b1) begin n_fail++; $display("FAIL mis_fault: got %b expected 1", bus.fetch_fault); end
        step(); step();
        n_checks++; if (bus.pc_q !== 32'h208) begin n_fail++; $display("FAIL mis_run_pc: got %h expected 00000208", bus.pc_q); end
        n_checks++; if (bus.if_id_instr !== 32'hC0DE_0204) begin n_fail++; $display("FAIL mis_run_instr: got %h expected c0de0204", bus.if_id_instr); end
        n_checks++; if (bus.fetch_fault !== 1'b1) begin n_fail++; $display("FAIL mis_sticky: got %b expected 1", bus.fetch_fault); end
    endtask

    task automatic test_range_and_reset();
        @(negedge clk);
        rst_n = 0;
        #2;
        rst_n = 1;
        n_checks++; if (bus.fetch_fault !== 1'b0) begin n_fail++; $display("FAIL rr_fault_clr: got %b expected 0", bus.fetch_fault); end
        bus.branch_taken = 1; bus.branch_target = 32'd16380;
        step();
        clear_ctrl();
        n_checks++; if (bus.pc_q !== 32'd16380) begin n_fail++; $display("FAIL rng_pc0: got %h expected %h", bus.pc_q, 32'd16380); end
        step();
        n_checks++; if (bus.if_id_valid !== 1'b1) begin n_fail++; $display("FAIL rng_last_valid: got %b expected 1", bus.if_id_valid); end
        n_checks++; if (bus.if_id_instr !== 32'hC0DE_3FFC) begin n_fail++; $display("FAIL rng_last_instr: got %h expected c0de3ffc", bus.if_id_instr); end
        n_checks++; if (bus.pc_q !== 32'd16384) begin n_fail++; $display("FAIL rng_pc1: got %h expected %h", bus.pc_q, 32'd16384); end
        n_checks++; if (bus.fetch_fault !== 1'b0) begin n_fail++; $display("FAIL rng_fault_early: got %b expected 0", bus.fetch_fault); end
        step(); step();
        n_checks++; if (bus.if_id_valid !== 1'b0) begin n_fail++; $display("FAIL rng_bubble_valid: got %b expected 0", bus.if_id_valid); end
        n_checks++; if (bus.if_id_instr !== 32'd0) begin n_fail++; $display("FAIL rng_bubble_instr: got %h expected 0", bus.if_id_instr); end
        n_checks++; if (bus.pc_q !== 32'd16384) begin n_fail++; $display("FAIL rng_pc_hold: got %h expected %h", bus.pc_q, 32'd16384); end
        n_checks++; if (bus.fetch_fault !== 1'b1) begin n_fail++; $display("FAIL rng_fault: got %b expected 1", bus.fetch_fault); end
        bus.jump = 1; bus.jump_target = 32'd100;
        step();
        clear_ctrl();
        n_checks++; if (bus.pc_q !== 32'd100) begin n_fail++; $display("FAIL resume_pc: got %h expected %h", bus.pc_q, 32'd100); end
        step();
        n_checks++; if (bus.if_id_instr !== 32'h4808_0000) begin n_fail++; $display("FAIL resume_instr: got %h expected 48080000", bus.if_id_instr); end
        n_checks++; if (bus.if_id_valid !== 1'b1) begin n_fail++; $display("FAIL resume_valid: got %b expected 1", bus.if_id_valid); end
        step();
        @(negedge clk);
        #1;
        rst_n = 0;
        #1;
        n_checks++; if (bus.pc_q !== 32'd100) begin n_fail++; $display("FAIL arst_pc: got %h expected %h", bus.pc_q, 32'd100); end
        n_checks++; if (bus.if_id_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b expected 0", bus.if_id_valid); end
        n_checks++; if (bus.fetch_fault !== 1'b0) begin n_fail++; $display("FAIL arst_fault: got %b expected 0", bus.fetch_fault); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_stall();
        test_branch_over_stall();
        test_jump_priority();
        test_misaligned();
        test_range_and_reset();
        chk("final_reset_pc4", bus.if_id_pc4, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
